// File: rtl/posit_mult_arbiter.sv
// posit_mult_arbiter: two-requester window arbiter in front of one shared posit multiplier,
// with a tag FIFO that steers results back to their requester in issue order.
module posit_mult_arbiter #(
    parameter int POSIT_WIDTH = 16,
    parameter int POSIT_ES = 1,
    parameter int TAG_DEPTH = 4,
    localparam int FRACTION_SIZE_IN = POSIT_WIDTH - POSIT_ES - 3,
    localparam int SCALE_SIZE_IN = $clog2(POSIT_WIDTH) + POSIT_ES + 1,
    localparam int FRACTION_SIZE_OUT = 2 * (FRACTION_SIZE_IN + 1),
    localparam int SCALE_SIZE_OUT = SCALE_SIZE_IN + 1,
    localparam int OPW = 2 * (FRACTION_SIZE_IN + SCALE_SIZE_IN + 3),
    localparam int RSW = FRACTION_SIZE_OUT + SCALE_SIZE_OUT + 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_rts_i,
    input  logic           req0_sow_i,
    input  logic           req0_eow_i,
    input  logic [OPW-1:0] req0_data_i,
    output logic           req0_rtr_o,
    input  logic           req1_rts_i,
    input  logic           req1_sow_i,
    input  logic           req1_eow_i,
    input  logic [OPW-1:0] req1_data_i,
    output logic           req1_rtr_o,
    output logic           m_rts_o,
    output logic           m_sow_o,
    output logic           m_eow_o,
    output logic [OPW-1:0] m_data_o,
    input  logic           m_rtr_i,
    input  logic           r_rts_i,
    input  logic           r_sow_i,
    input  logic           r_eow_i,
    input  logic [RSW-1:0] r_data_i,
    output logic           r_rtr_o,
    output logic           res0_rts_o,
    output logic           res0_sow_o,
    output logic           res0_eow_o,
    output logic [RSW-1:0] res0_data_o,
    input  logic           res0_rtr_i,
    output logic           res1_rts_o,
    output logic           res1_sow_o,
    output logic           res1_eow_o,
    output logic [RSW-1:0] res1_data_o,
    input  logic           res1_rtr_i,
    output logic           err_o
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t               state_q;
    logic                 last_q, err_q;
    logic [TAG_DEPTH-1:0] tag_q;
    logic [PW-1:0]        wr_q, rd_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 g0, g1, full, empty, push, pop, head, sel0, sel1, e0, e1;

    always_comb begin
        g0 = state_q == GRANT0;
        g1 = state_q == GRANT1;
        full = cnt_q == CW'(TAG_DEPTH);
        empty = cnt_q == '0;
        m_rts_o = (g0 ? req0_rts_i : g1 & req1_rts_i) & ~full;
        m_sow_o = g0 ? req0_sow_i : g1 & req1_sow_i;
        m_eow_o = g0 ? req0_eow_i : g1 & req1_eow_i;
        m_data_o = g0 ? req0_data_i : g1 ? req1_data_i : '0;
        req0_rtr_o = g0 & m_rtr_i & ~full;
        req1_rtr_o = g1 & m_rtr_i & ~full;
        push = m_rts_o & m_rtr_i;
        head = tag_q[rd_q];
        sel0 = ~empty & ~head;
        sel1 = ~empty & head;
        res0_rts_o = sel0 & r_rts_i;
        res0_sow_o = sel0 & r_sow_i;
        res0_eow_o = sel0 & r_eow_i;
        res0_data_o = sel0 ? r_data_i : '0;
        res1_rts_o = sel1 & r_rts_i;
        res1_sow_o = sel1 & r_sow_i;
        res1_eow_o = sel1 & r_eow_i;
        res1_data_o = sel1 ? r_data_i : '0;
        r_rtr_o = (sel0 & res0_rtr_i) | (sel1 & res1_rtr_i);
        pop = r_rts_i & r_rtr_o;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        e0 = req0_rts_i & req0_sow_i;
        e1 = req1_rts_i & req1_sow_i;
    end

    assign err_o = err_q;

    // On a tie the grant goes to the requester that did not win last time
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q <= 1'b1;
        end else if (!g0 && !g1) begin
            state_q <= e0 & (~e1 | last_q) ? GRANT0 : e1 ? GRANT1 : IDLE;
        end else if (push && m_eow_o) begin
            state_q <= IDLE;
            last_q <= g1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_q] <= g1;
                wr_q <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
            err_q <= err_q | (r_rts_i & empty);
        end
    end
endmodule

// File: tb/tb_posit_mult_arbiter.sv
// tb_posit_mult_arbiter: directed scoreboard bench; the bench also plays the shared multiplier.
module tb_posit_mult_arbiter;
    localparam int PWID = 16;
    localparam int PES = 1;
    localparam int FSI = PWID - PES - 3;
    localparam int SSI = $clog2(PWID) + PES + 1;
    localparam int OPW = 2 * (FSI + SSI + 3);
    localparam int RSW = 2 * (FSI + 1) + SSI + 1 + 3;

    typedef struct packed {
        logic           tag;
        logic [RSW-1:0] data;
    } exp_t;

    logic clk = 0, rst_n;
    logic req0_rts_i, req0_sow_i, req0_eow_i, req0_rtr_o;
    logic req1_rts_i, req1_sow_i, req1_eow_i, req1_rtr_o;
    logic [OPW-1:0] req0_data_i, req1_data_i, m_data_o;
    logic m_rts_o, m_sow_o, m_eow_o, m_rtr_i;
    logic r_rts_i = 0, r_sow_i = 1, r_eow_i = 1, r_rtr_o;
    logic [RSW-1:0] r_data_i = '0, res0_data_o, res1_data_o;
    logic res0_rts_o, res0_sow_o, res0_eow_o, res0_rtr_i;
    logic res1_rts_o, res1_sow_o, res1_eow_o, res1_rtr_i;
    logic err_o;

    int checks = 0, errors = 0;
    exp_t expq[$];
    logic [OPW-1:0] mq[$];
    bit r_en = 0, r_force = 0;

    posit_mult_arbiter #(.POSIT_WIDTH(PWID), .POSIT_ES(PES), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_rts_i(req0_rts_i), .req0_sow_i(req0_sow_i), .req0_eow_i(req0_eow_i),
        .req0_data_i(req0_data_i), .req0_rtr_o(req0_rtr_o),
        .req1_rts_i(req1_rts_i), .req1_sow_i(req1_sow_i), .req1_eow_i(req1_eow_i),
        .req1_data_i(req1_data_i), .req1_rtr_o(req1_rtr_o),
        .m_rts_o(m_rts_o), .m_sow_o(m_sow_o), .m_eow_o(m_eow_o), .m_data_o(m_data_o),
        .m_rtr_i(m_rtr_i),
        .r_rts_i(r_rts_i), .r_sow_i(r_sow_i), .r_eow_i(r_eow_i), .r_data_i(r_data_i),
        .r_rtr_o(r_rtr_o),
        .res0_rts_o(res0_rts_o), .res0_sow_o(res0_sow_o), .res0_eow_o(res0_eow_o),
        .res0_data_o(res0_data_o), .res0_rtr_i(res0_rtr_i),
        .res1_rts_o(res1_rts_o), .res1_sow_o(res1_sow_o), .res1_eow_o(res1_eow_o),
        .res1_data_o(res1_data_o), .res1_rtr_i(res1_rtr_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [RSW-1:0] fm(input logic [OPW-1:0] op);
        return op[RSW-1:0] ^ op[OPW-1 -: RSW];
    endfunction

    function automatic logic [OPW-1:0] rnd();
        logic [63:0] w = {$urandom(), $urandom()};
        return w[OPW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input bit k, input bit r, input bit s, input bit e, input logic [OPW-1:0] d);
        if (k) begin
            req1_rts_i = r; req1_sow_i = s; req1_eow_i = e; req1_data_i = d;
        end else begin
            req0_rts_i = r; req0_sow_i = s; req0_eow_i = e; req0_data_i = d;
        end
    endtask

    // Present one beat from requester k and hold it until accepted
    task automatic beat(input bit k, input bit s, input bit e, input logic [OPW-1:0] d);
        int n = 0;
        bit done = 0;
        setreq(k, 1, s, e, d);
        while (!done && n < 100) begin
            @(negedge clk);
            chk("other_rtr_low", k ? req0_rtr_o : req1_rtr_o, 0);
            if (k ? req1_rtr_o : req0_rtr_o) begin
                chk("m_data_fwd", m_data_o, d);
                expq.push_back('{k, fm(d)});
                done = 1;
            end
            cyc();
            n++;
        end
        if (!done) chk("beat_timeout", 0, 1);
        setreq(k, 0, 0, 0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        chk("drain", expq.size(), 0);
    endtask

    // Multiplier model plus result-port monitor
    initial begin
        bit mfire, rfire, f0, f1;
        logic [OPW-1:0] mdat;
        exp_t e;
        forever begin
            @(negedge clk);
            mfire = m_rts_o & m_rtr_i;
            mdat = m_data_o;
            rfire = r_rts_i & r_rtr_o;
            f0 = res0_rts_o & res0_rtr_i;
            f1 = res1_rts_o & res1_rtr_i;
            if (f0 || f1) begin
                if (expq.size() == 0) chk("res_unexpected", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("res_port", f1, e.tag);
                    chk("res_data", f1 ? res1_data_o : res0_data_o, e.data);
                    chk("res_other_quiet", f1 ? res0_rts_o : res1_rts_o, 0);
                end
            end
            @(posedge clk);
            #2;
            if (rfire && mq.size() != 0) void'(mq.pop_front());
            if (mfire) mq.push_back(mdat);
            r_rts_i = r_force | (r_en && mq.size() != 0);
            r_data_i = mq.size() != 0 ? fm(mq[0]) : '0;
        end
    end

    initial begin
        logic [OPW-1:0] d, d0;
        int acc;
        rst_n = 0;
        setreq(0, 0, 0, 0, '0);
        setreq(1, 0, 0, 0, '0);
        m_rtr_i = 1; res0_rtr_i = 1; res1_rtr_i = 1;
        cyc(); cyc();
        rst_n = 1;
        @(negedge clk);
        chk("rst_err", err_o, 0);
        chk("rst_req0_rtr", req0_rtr_o, 0);
        chk("rst_req1_rtr", req1_rtr_o, 0);
        chk("rst_m_rts", m_rts_o, 0);
        chk("rst_r_rtr", r_rtr_o, 0);
        chk("rst_res_rts", {res1_rts_o, res0_rts_o}, 0);
        cyc();
        r_en = 1;

        // Simultaneous requests: req0 wins first tie, 3-beat window, then req1
        d = rnd();
        setreq(1, 1, 1, 1, d);
        beat(0, 1, 0, rnd());
        setreq(1, 1, 1, 1, d);
        beat(0, 0, 0, rnd());
        setreq(1, 1, 1, 1, d);
        beat(0, 0, 1, rnd());
        beat(1, 1, 1, d);
        drain();

        // Single-datum window from req1
        d = rnd();
        setreq(1, 1, 1, 1, d);
        @(negedge clk);
        chk("single_idle_rtr", req1_rtr_o, 0);
        cyc();
        @(negedge clk);
        chk("single_grant_rtr", req1_rtr_o, 1);
        chk("single_m_eow", m_eow_o, 1);
        chk("single_m_data", m_data_o, d);
        expq.push_back('{1'b1, fm(d)});
        cyc();
        setreq(1, 1, 0, 0, d);
        @(negedge clk);
        chk("single_back_idle", req1_rtr_o, 0);
        chk("single_idle_m_rts", m_rts_o, 0);
        cyc();
        setreq(1, 0, 0, 0, '0);
        drain();

        // Result path stalled: tag FIFO fills at 4 and blocks even during a pop
        res0_rtr_i = 0;
        acc = 0;
        d = rnd();
        setreq(0, 1, 1, 0, d);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req0_rtr_o) begin
                expq.push_back('{1'b0, fm(d)});
                acc++;
            end
            cyc();
            if (acc != 0) begin
                if (req0_data_i == d && acc > 0 && expq[expq.size()-1].data == fm(d)) d = rnd();
                setreq(0, 1, 0, 0, d);
            end
        end
        @(negedge clk);
        chk("full_accepted", acc, 4);
        chk("full_rtr", req0_rtr_o, 0);
        chk("full_m_rts", m_rts_o, 0);
        chk("full_res0_rts", res0_rts_o, 1);
        chk("full_r_rtr", r_rtr_o, 0);
        cyc();
        res0_rtr_i = 1;
        @(negedge clk);
        chk("full_pop_blocks_push", req0_rtr_o, 0);
        chk("full_pop_r_rtr", r_rtr_o, 1);
        cyc();
        res0_rtr_i = 0;
        @(negedge clk);
        chk("after_pop_rtr", req0_rtr_o, 1);
        expq.push_back('{1'b0, fm(d)});
        cyc();
        d = rnd();
        setreq(0, 1, 0, 1, d);
        @(negedge clk);
        chk("refull_rtr", req0_rtr_o, 0);
        cyc();
        res0_rtr_i = 1;
        beat(0, 0, 1, d);
        drain();

        // Tie after req0 last won goes to req1; req1 pauses mid-window
        d0 = rnd();
        setreq(0, 1, 1, 0, d0);
        beat(1, 1, 0, rnd());
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("pause_other_rtr", req0_rtr_o, 0);
            chk("pause_grant_rtr", req1_rtr_o, 1);
            chk("pause_m_rts", m_rts_o, 0);
            cyc();
        end
        beat(1, 0, 0, rnd());
        beat(1, 0, 1, rnd());
        beat(0, 1, 0, d0);
        beat(0, 0, 1, rnd());
        drain();

        // rts without sow is ignored in IDLE
        setreq(0, 1, 0, 0, rnd());
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("nosow_rtr", req0_rtr_o, 0);
            chk("nosow_m_rts", m_rts_o, 0);
            cyc();
        end
        setreq(0, 0, 0, 0, '0);

        // Stray result with empty FIFO sets sticky error
        r_en = 0;
        r_force = 1;
        @(negedge clk);
        chk("stray_err_before", err_o, 0);
        chk("stray_r_rtr", r_rtr_o, 0);
        chk("stray_res_rts", {res1_rts_o, res0_rts_o}, 0);
        cyc();
        r_force = 0;
        @(negedge clk);
        chk("stray_err_set", err_o, 1);
        cyc(); cyc(); cyc();
        @(negedge clk);
        chk("stray_err_sticky", err_o, 1);
        cyc();
        rst_n = 0;
        cyc();
        rst_n = 1;
        @(negedge clk);
        chk("stray_err_cleared", err_o, 0);
        cyc();

        // Reset mid-window drops grant and tags; late results flag an error
        beat(0, 1, 0, rnd());
        beat(0, 0, 0, rnd());
        setreq(0, 1, 0, 0, rnd());
        rst_n = 0;
        cyc();
        rst_n = 1;
        setreq(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("midrst_req0_rtr", req0_rtr_o, 0);
        chk("midrst_req1_rtr", req1_rtr_o, 0);
        chk("midrst_m_rts", m_rts_o, 0);
        chk("midrst_r_rtr", r_rtr_o, 0);
        chk("midrst_err", err_o, 0);
        expq.delete();
        cyc();
        r_en = 1;
        @(negedge clk);
        chk("midrst_res0_rts", res0_rts_o, 0);
        chk("midrst_late_r_rtr", r_rtr_o, 0);
        cyc();
        @(negedge clk);
        chk("midrst_late_err", err_o, 1);
        cyc();
        r_en = 0;
        mq.delete();
        cyc();
        chk("final_sb_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/posit_mult_arbiter.md
POSIT_MULT_ARBITER -- requirements
Module: posit_mult_arbiter

Interface
REQ-001 SHALL expose parameter POSIT_WIDTH, default 16, posit width forwarded to the shared multiplier.
REQ-002 SHALL expose parameter POSIT_ES, default 1, exponent size forwarded to the shared multiplier.
REQ-003 SHALL expose parameter TAG_DEPTH, default 4, in-flight tag FIFO depth (power of two, >=3).
REQ-004 SHALL derive OPW = 2*(FRACTION_SIZE_IN + SCALE_SIZE_IN + 3) and RSW = FRACTION_SIZE_OUT + SCALE_SIZE_OUT + 3 from the posit width macros (operand-pair and result bundles).
REQ-005 Port order: clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 reqK_rts_i / reqK_sow_i / reqK_eow_i (K=0,1)  in  1 each  requester K handshake and window markers.
REQ-008 reqK_data_i  in  OPW  requester K opaque operand pair.
REQ-009 reqK_rtr_o  out  1  requester K accepted.
REQ-010 m_rts_o / m_sow_o / m_eow_o  out  1 each;  m_data_o  out  OPW;  m_rtr_i  in  1  -- multiplier slave side.
REQ-011 r_rts_i / r_sow_i / r_eow_i  in  1 each;  r_data_i  in  RSW;  r_rtr_o  out  1  -- multiplier master side.
REQ-012 resK_rts_o / resK_sow_o / resK_eow_o  out  1 each;  resK_data_o  out  RSW;  resK_rtr_i  in  1  -- result return to requester K.
REQ-013 err_o  out  1  sticky protocol error.

Function
REQ-014 A transfer on any port SHALL occur in a cycle where its rts and rtr are both high.
REQ-015 FSM states SHALL be IDLE, GRANT0, GRANT1.
REQ-016 IDLE: a requester is eligible when rts_i=1 and sow_i=1; if one is eligible, go to its GRANT state next cycle; if both, grant the one not in last_grant; rts_i without sow_i SHALL be ignored (rtr_o low).
REQ-017 GRANTk: hold the grant until a transfer from requester k with eow_i=1, then return to IDLE the next cycle and set last_grant=k.
REQ-018 sow_i=1 and eow_i=1 on the same beat SHALL be a one-datum window: granted, one transfer, back to IDLE.
REQ-019 While granted and reqk_rts_i=0, the grant SHALL hold; there is no timeout.
REQ-020 Forward path, zero latency, combinational: m_rts_o = reqk_rts_i & ~tag_full in GRANTk; reqk_rtr_o = m_rtr_i & ~tag_full in GRANTk; m_sow_o, m_eow_o, m_data_o = granted requester's inputs.
REQ-021 Non-granted requester rtr_o SHALL be 0; m_rts_o SHALL be 0 in IDLE.
REQ-022 Each forward transfer SHALL push tag k into the tag FIFO.
REQ-023 Push SHALL be blocked while full, even if a pop occurs in the same cycle.
REQ-024 Return path: with FIFO non-empty and head tag h, resh_rts_o = r_rts_i and r_rtr_o = resh_rtr_i.
REQ-025 Return data and sow/eow SHALL be routed to resh_* only; the other res port's rts_o SHALL be 0.
REQ-026 Each return transfer SHALL pop the FIFO.
REQ-027 A simultaneous push and pop SHALL keep occupancy unchanged.
REQ-028 FIFO empty: r_rtr_o=0 and all resK_rts_o=0; if r_rts_i=1 while empty, err_o SHALL set and remain set until reset.
REQ-029 Results SHALL return to requesters in issue order; no reordering.

Reset
REQ-030 While rst_n=0 at a clk edge: FSM=IDLE, last_grant=1 (requester 0 wins first tie), FIFO empty, err_o=0.
REQ-031 All rts_o/rtr_o SHALL be 0 the cycle after reset.
REQ-032 Reset mid-window SHALL drop the grant and all in-flight tags; results returning afterwards SHALL set err_o.

Verification
REQ-033 Both requesters assert rts+sow in the same cycle after reset -> GRANT0 first; req0 3-beat window (eow on beat 3) completes, then GRANT1; results arrive on res0 x3, then res1.
REQ-034 req1 single beat sow=eow=1 while req0 idle -> one m transfer, res1 receives the result, FSM back in IDLE 2 cycles after the grant.
REQ-035 m_rtr_i held high, r_rtr_i path stalled (res0_rtr_i=0) -> exactly TAG_DEPTH=4 beats accepted, then req0_rtr_o=0 until one res0 pop.
REQ-036 Granted requester drops rts for 5 cycles mid-window -> grant held, other requester's rtr_o stays 0, window resumes.
REQ-037 r_rts_i pulsed with empty FIFO -> err_o=1 next cycle and remains 1; rst_n low for one cycle -> err_o=0.
REQ-038 req0 asserts rts without sow in IDLE -> req0_rtr_o=0 and no grant, for 10 cycles.
